vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Parametrised VGA/raster timing generator, successor to the fixed 640x480 sync block. All porch, sync and active widths are parameters, and sync polarity is selectable per axis. A clock-enable lets it run from the system clock instead of a divided pixel clock. It adds display-enable, blanking, frame/line strobes and a frame counter, and feeds the pixel pipeline and the DAC/pin stage.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BACK, 48, horizontal back porch (pixels, >=1)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch (lines, >=1)
H_SYNC_POL, 0, active level of HorizontalSync (0 = negative pulse)
V_SYNC_POL, 0, active level of VerticalSync
CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1
FRAME_W, 8, frame counter width

Ports:
Clock  input  1  system clock
ResetN  input  1  asynchronous reset, active low
Enable  input  1  pixel-clock enable; timing advances only on edges with Enable=1
HorizontalCounter  output  CNT_W  pixel position in line, 0..H_TOTAL-1
VerticalCounter  output  CNT_W  line position in frame, 0..V_TOTAL-1
HorizontalSync  output  1  horizontal sync
VerticalSync  output  1  vertical sync
DisplayEnable  output  1  high while in the active area
VerticalBlank  output  1  high while VerticalCounter >= V_ACTIVE
LineStart  output  1  one-Clock strobe on entry to HorizontalCounter=0
FrameStart  output  1  one-Clock strobe on entry to (0,0)
FrameCount  output  FRAME_W  completed-frame count, wraps modulo 2^FRAME_W

Behaviour:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (default 800); V_TOTAL likewise (default 525). Counters are 0-based.
- Reset (ResetN=0, async):
  - HorizontalCounter=H_TOTAL-1, VerticalCounter=V_TOTAL-1.
  - HorizontalSync=~H_SYNC_POL, VerticalSync=~V_SYNC_POL.
  - DisplayEnable=0, VerticalBlank=1, LineStart=0, FrameStart=0, FrameCount=0.
  - These values equal the decode of the last back-porch position.
- Every output is registered. On any edge, all outputs describe the same (h,v) as the counters. There is no decode skew between counters, syncs and DisplayEnable.
- Enabled edge (Enable=1):
  - h <= h+1; at h=H_TOTAL-1, h <= 0 and v <= v+1.
  - At v=V_TOTAL-1 together with h=H_TOTAL-1, v <= 0.
- Enable=0: counters, syncs, DisplayEnable and VerticalBlank hold; LineStart and FrameStart are 0.
- HorizontalSync = H_SYNC_POL when H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC, else ~H_SYNC_POL.
- VerticalSync = V_SYNC_POL when V_ACTIVE+V_FRONT <= v < V_ACTIVE+V_FRONT+V_SYNC, else inverse. The vertical decode uses v only, so VerticalSync changes on the same edge that v changes (at h=0).
- DisplayEnable = (h < H_ACTIVE) && (v < V_ACTIVE).
- LineStart = 1 for exactly the Clock cycle following an enabled edge that produced h=0.
- FrameStart = 1 for exactly the Clock cycle following an enabled edge that produced (h,v)=(0,0). FrameStart implies LineStart.
- FrameCount increments on the edge that produces (0,0), except the first (0,0) after reset. That first wrap raises FrameStart but leaves FrameCount=0.
- Reset asserted mid-frame: outputs return to reset values immediately. The first enabled edge after release yields (0,0) with LineStart=FrameStart=1.
- Counter arithmetic is CNT_W bits, unsigned; wrap is by compare, never by overflow.

Test Plan:
- Reset check: hold ResetN=0 -> h=799, v=524, HorizontalSync=1, VerticalSync=1, DisplayEnable=0, VerticalBlank=1, FrameCount=0. Release with Enable=1 -> next edge gives h=0, v=0, FrameStart=LineStart=1, DisplayEnable=1.
- Defaults, Enable=1, two frames:
  - FrameStart period = 420000 Clocks; LineStart period = 800.
  - HorizontalSync low exactly for h=656..751.
  - VerticalSync low exactly for v=490..491.
  - DisplayEnable high count per frame = 307200.
  - FrameCount goes 0 -> 1 at the second FrameStart.
- Enable toggled 1,0,1,0 (Clock50-style) -> FrameStart period = 840000 Clocks; strobes are one Clock wide; outputs hold during Enable=0.
- ResetN pulsed low at h=300, v=200 -> immediate return to reset values; restart at (0,0) with FrameStart and FrameCount=0.
- Small parameters: H 4/1/2/1, V 3/1/1/1, H_SYNC_POL=V_SYNC_POL=1, FRAME_W=2:
  - H_TOTAL=8, V_TOTAL=6.
  - HorizontalSync high for h=5..6; VerticalSync high for v=4.
  - FrameCount wraps 3 -> 0 on the fifth FrameStart.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counters, syncs, display enable, blanking,
// line/frame strobes and a completed-frame counter, all registered on the same (h,v).
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned CNT_W      = 10,
  parameter int unsigned FRAME_W    = 8
) (
  input  logic               Clock,
  input  logic               ResetN,
  input  logic               Enable,
  output logic [CNT_W-1:0]   HorizontalCounter,
  output logic [CNT_W-1:0]   VerticalCounter,
  output logic               HorizontalSync,
  output logic               VerticalSync,
  output logic               DisplayEnable,
  output logic               VerticalBlank,
  output logic               LineStart,
  output logic               FrameStart,
  output logic [FRAME_W-1:0] FrameCount
);

  localparam int unsigned HTotal = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VTotal = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] HLast      = CNT_W'(HTotal - 1);
  localparam logic [CNT_W-1:0] VLast      = CNT_W'(VTotal - 1);
  localparam logic [CNT_W-1:0] HActive    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] VActive    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HSyncStart = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] HSyncEnd   = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VSyncStart = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] VSyncEnd   = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
  logic               hs_q, hs_d, vs_q, vs_d;
  logic               de_q, de_d, vb_q, vb_d;
  logic               ls_q, ls_d, fs_q, fs_d;
  logic [FRAME_W-1:0] fc_q, fc_d;
  // Set until the first frame wrap after reset, which must not count as a completed frame.
  logic               first_q, first_d;

  // Next position, then decode every output from that next position so nothing skews.
  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    fc_d    = fc_q;
    first_d = first_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    if (Enable) begin
      if (h_q == HLast) begin
        h_d  = '0;
        v_d  = (v_q == VLast) ? '0 : v_q + CNT_W'(1);
        ls_d = 1'b1;
        fs_d = (v_q == VLast);
      end else begin
        h_d = h_q + CNT_W'(1);
      end
    end
    if (fs_d) begin
      if (first_q) begin
        first_d = 1'b0;
      end else begin
        fc_d = fc_q + FRAME_W'(1);
      end
    end
    // With Enable low h_d/v_d equal the current position, so these decodes hold.
    hs_d = ((h_d >= HSyncStart) && (h_d < HSyncEnd)) ? H_SYNC_POL : ~H_SYNC_POL;
    vs_d = ((v_d >= VSyncStart) && (v_d < VSyncEnd)) ? V_SYNC_POL : ~V_SYNC_POL;
    de_d = (h_d < HActive) && (v_d < VActive);
    vb_d = (v_d >= VActive);
  end

  // State and output registers; reset parks on the last back-porch position.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      h_q     <= HLast;
      v_q     <= VLast;
      hs_q    <= ~H_SYNC_POL;
      vs_q    <= ~V_SYNC_POL;
      de_q    <= 1'b0;
      vb_q    <= 1'b1;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '0;
      first_q <= 1'b1;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
      vb_q    <= vb_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
      first_q <= first_d;
    end
  end

  assign HorizontalCounter = h_q;
  assign VerticalCounter   = v_q;
  assign HorizontalSync    = hs_q;
  assign VerticalSync      = vs_q;
  assign DisplayEnable     = de_q;
  assign VerticalBlank     = vb_q;
  assign LineStart         = ls_q;
  assign FrameStart        = fs_q;
  assign FrameCount        = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 timing plus a tiny-parameter instance.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_d = 1'b0;
  logic en_s = 1'b0;

  always #5 clk = ~clk;

  // Default-parameter instance.
  logic [9:0] d_h, d_v;
  logic       d_hs, d_vs, d_de, d_vb, d_ls, d_fs;
  logic [7:0] d_fc;

  vga_timing_gen u_dflt (
    .Clock             (clk),
    .ResetN            (rst_n),
    .Enable            (en_d),
    .HorizontalCounter (d_h),
    .VerticalCounter   (d_v),
    .HorizontalSync    (d_hs),
    .VerticalSync      (d_vs),
    .DisplayEnable     (d_de),
    .VerticalBlank     (d_vb),
    .LineStart         (d_ls),
    .FrameStart        (d_fs),
    .FrameCount        (d_fc)
  );

  // Small instance: H 4/1/2/1 (total 8), V 3/1/1/1 (total 6), positive syncs.
  logic [2:0] s_h, s_v;
  logic       s_hs, s_vs, s_de, s_vb, s_ls, s_fs;
  logic [1:0] s_fc;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .CNT_W(3), .FRAME_W(2)
  ) u_small (
    .Clock             (clk),
    .ResetN            (rst_n),
    .Enable            (en_s),
    .HorizontalCounter (s_h),
    .VerticalCounter   (s_v),
    .HorizontalSync    (s_hs),
    .VerticalSync      (s_vs),
    .DisplayEnable     (s_de),
    .VerticalBlank     (s_vb),
    .LineStart         (s_ls),
    .FrameStart        (s_fs),
    .FrameCount        (s_fc)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_d(input string tag, input int h, input int v, input bit hs, input bit vs,
                       input bit de, input bit vb, input bit ls, input bit fs, input int fc);
    check({tag, ".h"},  32'(d_h),  32'(h));
    check({tag, ".v"},  32'(d_v),  32'(v));
    check({tag, ".hs"}, 32'(d_hs), 32'(hs));
    check({tag, ".vs"}, 32'(d_vs), 32'(vs));
    check({tag, ".de"}, 32'(d_de), 32'(de));
    check({tag, ".vb"}, 32'(d_vb), 32'(vb));
    check({tag, ".ls"}, 32'(d_ls), 32'(ls));
    check({tag, ".fs"}, 32'(d_fs), 32'(fs));
    check({tag, ".fc"}, 32'(d_fc), 32'(fc));
  endtask

  task automatic chk_s(input string tag, input int h, input int v, input bit hs, input bit vs,
                       input bit de, input bit vb, input bit ls, input bit fs, input int fc);
    check({tag, ".h"},  32'(s_h),  32'(h));
    check({tag, ".v"},  32'(s_v),  32'(v));
    check({tag, ".hs"}, 32'(s_hs), 32'(hs));
    check({tag, ".vs"}, 32'(s_vs), 32'(vs));
    check({tag, ".de"}, 32'(s_de), 32'(de));
    check({tag, ".vb"}, 32'(s_vb), 32'(vb));
    check({tag, ".ls"}, 32'(s_ls), 32'(ls));
    check({tag, ".fs"}, 32'(s_fs), 32'(fs));
    check({tag, ".fc"}, 32'(s_fc), 32'(fc));
  endtask

  initial begin
    int eh, ev, efc;
    bit els, efs, efirst;

    // Reset state of both instances.
    tick(3);
    chk_d("d_rst", 799, 524, 1, 1, 0, 1, 0, 0, 0);
    chk_s("s_rst", 7, 5, 0, 0, 0, 1, 0, 0, 0);

    // Release with Enable=1: first edge lands on (0,0) with both strobes.
    rst_n = 1'b1;
    en_d  = 1'b1;
    tick(1);
    chk_d("d_first", 0, 0, 1, 1, 1, 0, 1, 1, 0);
    tick(1);
    chk_d("d_h1", 1, 0, 1, 1, 1, 0, 0, 0, 0);
    tick(654);
    chk_d("d_h655", 655, 0, 1, 1, 0, 0, 0, 0, 0);
    tick(1);
    chk_d("d_h656", 656, 0, 0, 1, 0, 0, 0, 0, 0);
    tick(95);
    chk_d("d_h751", 751, 0, 0, 1, 0, 0, 0, 0, 0);
    tick(1);
    chk_d("d_h752", 752, 0, 1, 1, 0, 0, 0, 0, 0);
    tick(47);
    chk_d("d_h799", 799, 0, 1, 1, 0, 0, 0, 0, 0);
    tick(1);
    chk_d("d_line1", 0, 1, 1, 1, 1, 0, 1, 0, 0);

    // Enable low: everything holds, strobe drops after one clock.
    en_d = 1'b0;
    tick(1);
    chk_d("d_hold1", 0, 1, 1, 1, 1, 0, 0, 0, 0);
    tick(3);
    chk_d("d_hold4", 0, 1, 1, 1, 1, 0, 0, 0, 0);
    en_d = 1'b1;
    tick(1);
    chk_d("d_en_h1", 1, 1, 1, 1, 1, 0, 0, 0, 0);
    en_d = 1'b0;
    tick(1);
    chk_d("d_dis_h1", 1, 1, 1, 1, 1, 0, 0, 0, 0);

    // Asynchronous reset mid-line takes effect without a clock edge.
    en_d = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk_d("d_async_rst", 799, 524, 1, 1, 0, 1, 0, 0, 0);
    tick(2);
    chk_d("d_rst_hold", 799, 524, 1, 1, 0, 1, 0, 0, 0);
    rst_n = 1'b1;
    tick(1);
    chk_d("d_restart", 0, 0, 1, 1, 1, 0, 1, 1, 0);

    // Small instance: five-plus frames against a literal-constant reference.
    rst_n = 1'b0;
    en_d  = 1'b0;
    tick(2);
    rst_n = 1'b1;
    en_s  = 1'b1;
    eh = 7; ev = 5; efc = 0; efirst = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      tick(1);
      if (eh == 7) begin
        eh = 0;
        ev = (ev == 5) ? 0 : ev + 1;
      end else begin
        eh = eh + 1;
      end
      els = (eh == 0);
      efs = els && (ev == 0);
      if (efs) begin
        if (efirst) efirst = 1'b0;
        else efc = (efc + 1) % 4;
      end
      chk_s($sformatf("s_e%0d", i), eh, ev, (eh == 5 || eh == 6), (ev == 4),
            (eh < 4 && ev < 3), (ev >= 3), els, efs, efc);
      if (i == 1)   check("s_fc_first_wrap", 32'(s_fc), 32'd0);
      if (i == 145) check("s_fc_4th_fs", 32'(s_fc), 32'd3);
      if (i == 193) begin
        check("s_fc_5th_fs_wrap", 32'(s_fc), 32'd0);
        check("s_fs_5th", 32'(s_fs), 32'd1);
      end
    end

    // Edge 200 sits at (7,0); toggle Enable around the line wrap.
    en_s = 1'b0;
    tick(1);
    chk_s("s_hold", 7, 0, 0, 0, 0, 0, 0, 0, 0);
    en_s = 1'b1;
    tick(1);
    chk_s("s_line1", 0, 1, 0, 0, 1, 0, 1, 0, 0);
    en_s = 1'b0;
    tick(1);
    chk_s("s_ls_one_clk", 0, 1, 0, 0, 1, 0, 0, 0, 0);

    // Mid-frame reset on the small instance.
    #2 rst_n = 1'b0;
    #1;
    chk_s("s_async_rst", 7, 5, 0, 0, 0, 1, 0, 0, 0);
    tick(1);
    rst_n = 1'b1;
    en_s  = 1'b1;
    tick(1);
    chk_s("s_restart", 0, 0, 0, 0, 1, 0, 1, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
